// File: rtl/pal_timing_pkg.sv
// Shared constants and types for the PAL video timing controller.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// Holds the default horizontal timing for 14.75 MHz PAL, the line-count
// constants for interlaced (625) and progressive (312) scanning, the
// half-line pulse kinds and the active-line limits.
package pal_timing_pkg;

  // Default horizontal timing in pixel clocks (14.75 MHz, 944 clocks/line).
  localparam int H_TOTAL_DEF     = 944;
  localparam int H_SYNC_DEF      = 69;   // 4.7 us line sync
  localparam int H_EQ_DEF        = 35;   // 2.35 us equalising pulse
  localparam int H_BROAD_DEF     = 403;  // half line minus one line sync
  localparam int H_ACT_START_DEF = 152;  // sync + back porch
  localparam int H_ACTIVE_DEF    = 768;
  localparam int LEAD_DEF        = 2;

  // Vertical structure.
  localparam logic [9:0] LINES_INTERLACED  = 10'd625;
  localparam logic [9:0] LINES_PROG        = 10'd312;
  localparam logic [9:0] FIELD2_FIRST_LINE = 10'd313;

  // Active picture lines, inclusive.
  localparam logic [9:0] ACT_I_F1_FIRST = 10'd23;
  localparam logic [9:0] ACT_I_F1_LAST  = 10'd310;
  localparam logic [9:0] ACT_I_F2_FIRST = 10'd335;
  localparam logic [9:0] ACT_I_F2_LAST  = 10'd622;
  localparam logic [9:0] ACT_P_FIRST    = 10'd23;
  localparam logic [9:0] ACT_P_LAST     = 10'd308;

  // Pulse carried by one half of a line:
  //   HK_H line sync, HK_E equalising, HK_B broad, HK_N no pulse.
  typedef enum logic [1:0] {
    HK_H = 2'd0,
    HK_E = 2'd1,
    HK_B = 2'd2,
    HK_N = 2'd3
  } half_kind_t;

  // One sample of the delayed sync/active bundle.
  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic csync_n;
    logic active;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, csync_n: 1'b1, active: 1'b0};

  // Number of the last line of a frame for the given scan mode.
  function automatic logic [9:0] lines_per_frame(input logic prog);
    return prog ? LINES_PROG : LINES_INTERLACED;
  endfunction

endpackage

// File: rtl/pal_video_timing_ctrl_if.sv
// Timing bus between the PAL timing controller and its consumers.
// Latency: n/a (wires only).
// Backpressure: none; the timing stream is free-running.
//
// master: the timing controller (drives everything except mode_req).
// slave : the pattern generator / mode controller side.
//   mode_req     requested scan mode, 0 = interlaced 625, 1 = progressive 312
//   mode_ack     one-cycle pulse when a new mode takes effect
//   prog         mode currently applied
//   hc, vc       leading pixel/line coordinates (vc counts from 1)
//   field        leading field flag, 1 for lines 313..625 in interlaced mode
//   frame_start  leading pulse at hc=0, vc=1
//   hsync_n, vsync_n, csync_n, active  delayed sync/active outputs
interface pal_video_timing_ctrl_if;
  logic       mode_req;
  logic       mode_ack;
  logic       prog;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       field;
  logic       frame_start;
  logic       hsync_n;
  logic       vsync_n;
  logic       csync_n;
  logic       active;

  modport master (
    input  mode_req,
    output mode_ack, prog, hc, vc, field, frame_start,
    output hsync_n, vsync_n, csync_n, active
  );

  modport slave (
    output mode_req,
    input  mode_ack, prog, hc, vc, field, frame_start,
    input  hsync_n, vsync_n, csync_n, active
  );
endinterface

// File: rtl/pal_line_kind_lut.sv
// Line-number to half-line pulse kind and vsync window lookup.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   vc           current line number (1-based)
//   prog         0 = interlaced 625-line table, 1 = progressive 312-line table
//   first_kind   pulse kind starting at hc 0
//   second_kind  pulse kind starting at the half-line point
//   vs_first     vsync window covers the first half of this line
//   vs_second    vsync window covers the second half of this line
module pal_line_kind_lut
  import pal_timing_pkg::*;
(
  input  logic [9:0]  vc,
  input  logic        prog,
  output half_kind_t  first_kind,
  output half_kind_t  second_kind,
  output logic        vs_first,
  output logic        vs_second
);

  always_comb begin
    // Ordinary picture line: line sync only.
    first_kind  = HK_H;
    second_kind = HK_N;
    vs_first    = 1'b0;
    vs_second   = 1'b0;

    if (prog) begin
      if (vc <= 10'd2) begin
        first_kind  = HK_B;
        second_kind = HK_B;
      end else if (vc == 10'd3) begin
        first_kind  = HK_B;
        second_kind = HK_E;
      end else if (vc <= 10'd5) begin
        first_kind  = HK_E;
        second_kind = HK_E;
      end else if (vc >= 10'd310) begin
        first_kind  = HK_E;
        second_kind = HK_E;
      end
    end else begin
      if (vc <= 10'd2) begin
        first_kind  = HK_B;
        second_kind = HK_B;
      end else if (vc == 10'd3) begin
        first_kind  = HK_B;
        second_kind = HK_E;
      end else if (vc <= 10'd5) begin
        first_kind  = HK_E;
        second_kind = HK_E;
      end else if (vc <= 10'd310) begin
        first_kind  = HK_H;
        second_kind = HK_N;
      end else if (vc <= 10'd312) begin
        first_kind  = HK_E;
        second_kind = HK_E;
      end else if (vc == 10'd313) begin
        // Second field starts half a line in: broad pulses begin at mid-line.
        first_kind  = HK_E;
        second_kind = HK_B;
      end else if (vc <= 10'd315) begin
        first_kind  = HK_B;
        second_kind = HK_B;
      end else if (vc <= 10'd317) begin
        first_kind  = HK_E;
        second_kind = HK_E;
      end else if (vc == 10'd318) begin
        first_kind  = HK_E;
        second_kind = HK_N;
      end else if (vc <= 10'd622) begin
        first_kind  = HK_H;
        second_kind = HK_N;
      end else if (vc == 10'd623) begin
        first_kind  = HK_H;
        second_kind = HK_E;
      end else begin
        first_kind  = HK_E;
        second_kind = HK_E;
      end
    end

    // Field-1 vsync: (1, 0) up to (3, half line).
    if (vc <= 10'd2) begin
      vs_first  = 1'b1;
      vs_second = 1'b1;
    end else if (vc == 10'd3) begin
      vs_first  = 1'b1;
    end

    // Field-2 vsync: (313, half line) up to (316, 0).
    if (!prog) begin
      if (vc == 10'd313) begin
        vs_second = 1'b1;
      end else if (vc == 10'd314 || vc == 10'd315) begin
        vs_first  = 1'b1;
        vs_second = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pal_video_timing_ctrl.sv
// Master PAL timing sequencer: counters, composite sync, scan-mode switch.
// Latency: hc/vc/field/frame_start lead; syncs and active lag them by LEAD clocks.
// Backpressure: none; free-running, mode changes wait for the frame boundary.
//
// Ports:
//   clk   pixel clock
//   rst   synchronous active-high reset, aborts the frame immediately
//   vif   timing bus (master side): mode_req in; mode_ack, prog, hc, vc,
//         field, frame_start, hsync_n, vsync_n, csync_n, active out
module pal_video_timing_ctrl
  import pal_timing_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_EQ        = H_EQ_DEF,
  parameter int H_BROAD     = H_BROAD_DEF,
  parameter int H_ACT_START = H_ACT_START_DEF,
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int LEAD        = LEAD_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  pal_video_timing_ctrl_if.master vif
);

  localparam logic [9:0] HC_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] HC_HALF   = 10'(H_TOTAL / 2);
  localparam logic [9:0] W_SYNC    = 10'(H_SYNC);
  localparam logic [9:0] W_EQ      = 10'(H_EQ);
  localparam logic [9:0] W_BROAD   = 10'(H_BROAD);
  localparam logic [9:0] ACT_FIRST = 10'(H_ACT_START);
  localparam logic [9:0] ACT_LAST  = 10'(H_ACT_START + H_ACTIVE - 1);

  // ---------------------------------------------------------------------
  // Leading counters and mode handshake
  // ---------------------------------------------------------------------
  logic [9:0] hc_q;
  logic [9:0] vc_q;
  logic       field_q;
  logic       prog_q;
  logic       mode_ack_q;
  logic       frame_start_q;

  logic       end_of_line;
  logic       end_of_frame;
  logic [9:0] vc_next;

  assign end_of_line  = (hc_q == HC_LAST);
  assign end_of_frame = end_of_line && (vc_q == lines_per_frame(prog_q));

  always_comb begin
    vc_next = vc_q;
    if (end_of_frame) begin
      vc_next = 10'd1;
    end else if (end_of_line) begin
      vc_next = vc_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q          <= 10'd0;
      vc_q          <= 10'd1;
      field_q       <= 1'b0;
      prog_q        <= 1'b0;
      mode_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= end_of_line ? 10'd0 : hc_q + 10'd1;
      vc_q          <= vc_next;
      // Progressive frames never reach line 313, so field stays 0 there.
      field_q       <= (vc_next >= FIELD2_FIRST_LINE);
      frame_start_q <= end_of_frame;
      // mode_req is only looked at on the last clock of a frame, so a request
      // that comes and goes inside a frame is never seen.
      mode_ack_q    <= end_of_frame && (vif.mode_req != prog_q);
      if (end_of_frame) begin
        prog_q <= vif.mode_req;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sync and active decode from the leading coordinates
  // ---------------------------------------------------------------------
  half_kind_t first_kind;
  half_kind_t second_kind;
  logic       vs_first;
  logic       vs_second;

  pal_line_kind_lut u_lut (
    .vc          (vc_q),
    .prog        (prog_q),
    .first_kind  (first_kind),
    .second_kind (second_kind),
    .vs_first    (vs_first),
    .vs_second   (vs_second)
  );

  logic       second_half;
  logic [9:0] half_pos;
  half_kind_t kind;
  logic       pulse_low;
  logic       line_active;
  sync_t      sync_now;

  always_comb begin
    second_half = (hc_q >= HC_HALF);
    // Position within the current half line; every pulse starts at 0.
    half_pos    = second_half ? (hc_q - HC_HALF) : hc_q;
    kind        = second_half ? second_kind : first_kind;

    pulse_low = 1'b0;
    case (kind)
      HK_H:    pulse_low = (half_pos < W_SYNC);
      HK_E:    pulse_low = (half_pos < W_EQ);
      HK_B:    pulse_low = (half_pos < W_BROAD);
      default: pulse_low = 1'b0;
    endcase

    if (prog_q) begin
      line_active = (vc_q >= ACT_P_FIRST) && (vc_q <= ACT_P_LAST);
    end else begin
      line_active = ((vc_q >= ACT_I_F1_FIRST) && (vc_q <= ACT_I_F1_LAST)) ||
                    ((vc_q >= ACT_I_F2_FIRST) && (vc_q <= ACT_I_F2_LAST));
    end

    sync_now         = SYNC_IDLE;
    sync_now.hsync_n = ~(hc_q < W_SYNC);
    sync_now.vsync_n = ~(second_half ? vs_second : vs_first);
    sync_now.csync_n = ~pulse_low;
    sync_now.active  = line_active && (hc_q >= ACT_FIRST) && (hc_q <= ACT_LAST);
  end

  // ---------------------------------------------------------------------
  // LEAD-stage delay line; stage LEAD-1 drives the outputs. Reset clears
  // every stage, so outputs stay idle for LEAD clocks after reset release.
  // ---------------------------------------------------------------------
  sync_t dly_q [LEAD];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LEAD; i++) begin
        dly_q[i] <= SYNC_IDLE;
      end
    end else begin
      dly_q[0] <= sync_now;
      for (int i = 1; i < LEAD; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign vif.hc          = hc_q;
  assign vif.vc          = vc_q;
  assign vif.field       = field_q;
  assign vif.prog        = prog_q;
  assign vif.mode_ack    = mode_ack_q;
  assign vif.frame_start = frame_start_q;
  assign vif.hsync_n     = dly_q[LEAD-1].hsync_n;
  assign vif.vsync_n     = dly_q[LEAD-1].vsync_n;
  assign vif.csync_n     = dly_q[LEAD-1].csync_n;
  assign vif.active      = dly_q[LEAD-1].active;

endmodule

// File: doc/pal_video_timing_ctrl.md
Name: pal_video_timing_ctrl

Overview:
- Master timing sequencer for the 50 Hz PAL test-pattern core at 14.75 MHz: 944 clocks/line, 625 lines interlaced, or 312 lines progressive.
- Drives pixel coordinates to the pattern generator LEAD clocks ahead of the matching syncs and active-video flag.
- Builds full composite sync: hsync, equalising and broad pulses.
- Owns the interlaced/progressive mode switch, applied only at frame boundaries with a req/ack handshake.

Parameters:
H_TOTAL, 944, clocks per line
H_SYNC, 69, hsync low width (4.7 us)
H_EQ, 35, equalising pulse low width (2.35 us)
H_BROAD, 403, broad pulse low width (H_TOTAL/2 - H_SYNC)
H_ACT_START, 152, first active clock (sync + back porch)
H_ACTIVE, 768, active clocks per line
LEAD, 2, pipeline delay from coordinates to sync/active outputs (>=1)

Ports:
clk  in  1  pixel clock 14.75 MHz
rst  in  1  synchronous, active-high reset
mode_req  in  1  requested mode: 0 = interlaced 625, 1 = progressive 312
mode_ack  out  1  one-cycle pulse when a new mode takes effect
prog  out  1  mode currently applied
hc  out  10  horizontal count 0..H_TOTAL-1 (leading)
vc  out  10  line number 1..625 or 1..312 (leading)
field  out  1  0 = lines 1..312, 1 = lines 313..625; always 0 in progressive (leading)
frame_start  out  1  pulse when hc=0, vc=1 (leading)
hsync_n  out  1  delayed by LEAD
vsync_n  out  1  delayed by LEAD
csync_n  out  1  delayed by LEAD
active  out  1  delayed by LEAD

Behaviour:
- Clock and reset: single clock, clk. rst is synchronous and active-high.
- Reset values: hc=0, vc=1, field=0, prog=0, mode_ack=0, frame_start=0. All LEAD delay stages clear to hsync_n=1, vsync_n=1, csync_n=1, active=0.
- Reset mid-frame aborts the frame immediately. The first cycle after rst falls presents hc=0, vc=1.
- Counting: hc increments each clock and wraps from H_TOTAL-1 to 0. vc increments on that wrap and goes from the last line (625, or 312 in progressive) to 1.
- Half-line kinds: H = low for clocks 0..H_SYNC-1; E = low for H_EQ clocks; B = low for H_BROAD clocks; N = no pulse.
- Placement: first-half kind starts at hc 0; second-half kind starts at hc 472.
- Interlaced line table (first, second):
  - 1-2 B,B; 3 B,E; 4-5 E,E; 6-310 H,N
  - 311-312 E,E; 313 E,B; 314-315 B,B; 316-317 E,E; 318 E,N
  - 319-622 H,N; 623 H,E; 624-625 E,E
- Progressive line table: 1-2 B,B; 3 B,E; 4-5 E,E; 6-309 H,N; 310-312 E,E.
- csync_n is low exactly within these pulses.
- hsync_n is low for hc<H_SYNC on every line.
- vsync_n is low from (line 1, hc 0) to (line 3, hc 472). In interlaced mode it is also low from (313, 472) to (316, 0).
- active = hc in [H_ACT_START, H_ACT_START+H_ACTIVE-1] and vc in active lines:
  - interlaced: 23..310 or 335..622
  - progressive: 23..308
- Latency: syncs and active are computed from the current (hc, vc, field, prog) and registered through exactly LEAD stages. The output at cycle k+LEAD reflects the coordinates at cycle k.
- Mode handshake:
  - mode_req is sampled on the last clock of a frame (hc=H_TOTAL-1, last line).
  - If mode_req differs from prog, prog updates on that edge and mode_ack pulses for one cycle, coincident with frame_start.
  - A toggle that reverts before the frame boundary produces no ack.
  - The delayed syncs of the old frame drain unchanged.
- Every frame is complete: no partial frames except after reset.

Decomposition:
- pal_timing_pkg holds the H_* defaults, line-count constants, the half-line kind enum (H, E, B, N) and the active-line limits.
- Sub-module pal_line_kind_lut is combinational: (vc, prog) -> first and second half-line kinds plus vsync windows.
- The top level holds the counters, the mode handshake and the LEAD delay line.

Test Plan:
- Release reset -> hc=0, vc=1 on the first cycle; csync_n falls exactly LEAD cycles later; first 403-clock low (broad pulse) then high for 69 clocks, then the next broad pulse at hc 472.
- Run one interlaced frame (590,000 clocks) -> frame_start repeats every 590,000 clocks; line 6 csync low 69 clocks, line 318 has a single 35-clock pulse, line 623 has hsync plus an eq pulse at 472.
- Count active -> 768 per active line, 576 active lines per interlaced frame, vsync_n low 2.5 lines twice per frame.
- Raise mode_req mid-frame -> prog and mode_ack change only with the next frame_start; the next frame is 294,528 clocks; drop mode_req -> returns to 590,000.
- Toggle mode_req high then low within one frame -> no mode_ack, period unchanged.
- Assert rst at line 200, hc 500 for 3 cycles -> outputs inactive for LEAD cycles, then timing restarts from line 1 with broad pulses.
